// File: rtl/mult_pkg.sv
// Shared widths and the X1->X2 entry layout for the pipelined multiplier.
package mult_pkg;

  localparam int unsigned MULT_W       = 64;
  localparam int unsigned MULT_VEC     = 5;
  localparam int unsigned X1X2_ENTRY_W = 130;

  typedef struct packed {
    logic              select_msb;
    logic              signed_res;
    logic [MULT_W-1:0] carry;
    logic [MULT_W-1:0] sum;
  } x1x2_entry_t;

endpackage

// File: rtl/x1_multiplier_if.sv
// X0->X1 FIFO head / X1->X2 FIFO head signals seen by the X1 multiplier stage.
interface x1_multiplier_if;
  import mult_pkg::*;

  logic [MULT_VEC*MULT_W-1:0] RES_RX0;
  logic                       SELECT_MSB_RX0;
  logic                       SIGNED_RES_RX0;
  logic                       X0X1_EMPTY_SX0;
  logic                       X0X1_POP_SX1;
  logic                       X1X2_POP_SX2;
  logic [2*MULT_W-1:0]        RES_RX1;
  logic                       SELECT_MSB_RX1;
  logic                       SIGNED_RES_RX1;
  logic                       X1X2_EMPTY_SX1;

  modport slave (
    input  RES_RX0, SELECT_MSB_RX0, SIGNED_RES_RX0, X0X1_EMPTY_SX0, X1X2_POP_SX2,
    output X0X1_POP_SX1, RES_RX1, SELECT_MSB_RX1, SIGNED_RES_RX1, X1X2_EMPTY_SX1
  );

  modport master (
    output RES_RX0, SELECT_MSB_RX0, SIGNED_RES_RX0, X0X1_EMPTY_SX0, X1X2_POP_SX2,
    input  X0X1_POP_SX1, RES_RX1, SELECT_MSB_RX1, SIGNED_RES_RX1, X1X2_EMPTY_SX1
  );

endinterface

// File: rtl/x1_multiplier_csa.sv
// 64-bit 3:2 carry-save adder; the shifted-out majority bit is discarded.
module x1_multiplier_csa
  import mult_pkg::*;
(
  input  logic [MULT_W-1:0] a,
  input  logic [MULT_W-1:0] b,
  input  logic [MULT_W-1:0] c,
  output logic [MULT_W-1:0] s0,
  output logic [MULT_W-1:0] s1
);

  assign s0 = a ^ b ^ c;
  assign s1 = {(a[MULT_W-2:0] & b[MULT_W-2:0]) |
               (a[MULT_W-2:0] & c[MULT_W-2:0]) |
               (b[MULT_W-2:0] & c[MULT_W-2:0]), 1'b0};

endmodule

// File: rtl/x1_multiplier.sv
// X1 multiplier stage: reduces five carry-save vectors to a sum/carry pair and
// buffers the result in a small FIFO read by the X2 stage.
module x1_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  x1_multiplier_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [MULT_W-1:0] v [MULT_VEC];
  logic [MULT_W-1:0] a0, a1, b0, b1, sum_c, carry_c;

  x1x2_entry_t       mem_q [DEPTH];
  x1x2_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              full_c, empty_c, push_c, pop_c;
  x1x2_entry_t       wr_entry_c, head_c;

  always_comb begin
    for (int i = 0; i < MULT_VEC; i++) begin
      v[i] = bus.RES_RX0[i*MULT_W +: MULT_W];
    end
  end

  x1_multiplier_csa u_csa_l1 (.a(v[0]), .b(v[1]), .c(v[2]), .s0(a0),    .s1(a1));
  x1_multiplier_csa u_csa_l2 (.a(a0),   .b(a1),   .c(v[3]), .s0(b0),    .s1(b1));
  x1_multiplier_csa u_csa_l3 (.a(b0),   .b(b1),   .c(v[4]), .s0(sum_c), .s1(carry_c));

  assign wr_entry_c = '{select_msb: bus.SELECT_MSB_RX0,
                        signed_res: bus.SIGNED_RES_RX0,
                        carry:      carry_c,
                        sum:        sum_c};

  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);
  // A same-cycle pop frees the slot, so a full FIFO still accepts a push.
  assign push_c  = !bus.X0X1_EMPTY_SX0 && (!full_c || bus.X1X2_POP_SX2);
  assign pop_c   = bus.X1X2_POP_SX2 && !empty_c;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      mem_d[wr_ptr_q] = wr_entry_c;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_c             = mem_q[rd_ptr_q];
  assign bus.RES_RX1        = {head_c.carry, head_c.sum};
  assign bus.SELECT_MSB_RX1 = head_c.select_msb;
  assign bus.SIGNED_RES_RX1 = head_c.signed_res;
  assign bus.X1X2_EMPTY_SX1 = empty_c;
  assign bus.X0X1_POP_SX1   = push_c;

endmodule

// File: tb/tb_x1_multiplier.sv
// Directed bench for the X1 multiplier stage with DEPTH=2.
module tb_x1_multiplier;
  import mult_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  x1_multiplier_if bus ();

  x1_multiplier #(.DEPTH(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic drive_x0(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                          input logic [63:0] d, input logic [63:0] e,
                          input logic sel, input logic sgn);
    bus.RES_RX0        = {e, d, c, b, a};
    bus.SELECT_MSB_RX0 = sel;
    bus.SIGNED_RES_RX0 = sgn;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.X0X1_EMPTY_SX0 = 1'b1;
    bus.X1X2_POP_SX2   = 1'b0;
    drive_x0('0, '0, '0, '0, '0, 1'b0, 1'b0);
    #2;
    checks++; if (bus.X1X2_EMPTY_SX1 !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b exp=1", bus.X1X2_EMPTY_SX1); end
    checks++; if (bus.X0X1_POP_SX1 !== 1'b0) begin failures++; $display("FAIL rst_pop_idle got=%b exp=0", bus.X0X1_POP_SX1); end
    checks++; if (bus.RES_RX1 !== 128'd0) begin failures++; $display("FAIL rst_res got=%h exp=0", bus.RES_RX1); end
    checks++; if ({bus.SELECT_MSB_RX1, bus.SIGNED_RES_RX1} !== 2'b00) begin failures++; $display("FAIL rst_flags got=%b exp=00", {bus.SELECT_MSB_RX1, bus.SIGNED_RES_RX1}); end
    bus.X0X1_EMPTY_SX0 = 1'b0;
    #1;
    checks++; if (bus.X0X1_POP_SX1 !== 1'b1) begin failures++; $display("FAIL rst_pop_nonempty got=%b exp=1", bus.X0X1_POP_SX1); end
    bus.X0X1_EMPTY_SX0 = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.X1X2_EMPTY_SX1 !== 1'b1) begin failures++; $display("FAIL idle_empty got=%b exp=1", bus.X1X2_EMPTY_SX1); end
  endtask

  task automatic test_basic();
    drive_x0(64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 1'b1, 1'b0);
    bus.X0X1_EMPTY_SX0 = 1'b0;
    #1;
    checks++; if (bus.X0X1_POP_SX1 !== 1'b1) begin failures++; $display("FAIL basic_pop got=%b exp=1", bus.X0X1_POP_SX1); end
    @(posedge clk); #1;
    bus.X0X1_EMPTY_SX0 = 1'b1;
    #1;
    checks++; if (bus.X0X1_POP_SX1 !== 1'b0) begin failures++; $display("FAIL basic_pop_once got=%b exp=0", bus.X0X1_POP_SX1); end
    checks++; if (bus.X1X2_EMPTY_SX1 !== 1'b0) begin failures++; $display("FAIL basic_nonempty got=%b exp=0", bus.X1X2_EMPTY_SX1); end
    checks++; if (bus.RES_RX1 !== {64'd0, 64'd15}) begin failures++; $display("FAIL basic_res got=%h exp=%h", bus.RES_RX1, {64'd0, 64'd15}); end
    checks++; if ({bus.SELECT_MSB_RX1, bus.SIGNED_RES_RX1} !== 2'b10) begin failures++; $display("FAIL basic_flags got=%b exp=10", {bus.SELECT_MSB_RX1, bus.SIGNED_RES_RX1}); end
    bus.X1X2_POP_SX2 = 1'b1;
    @(posedge clk); #1;
    bus.X1X2_POP_SX2 = 1'b0;
    checks++; if (bus.X1X2_EMPTY_SX1 !== 1'b1) begin failures++; $display("FAIL basic_drained got=%b exp=1", bus.X1X2_EMPTY_SX1); end
  endtask

  task automatic test_all_ones();
    drive_x0(ONES, ONES, ONES, 64'd0, 64'd0, 1'b0, 1'b1);
    bus.X0X1_EMPTY_SX0 = 1'b0;
    @(posedge clk); #1;
    bus.X0X1_EMPTY_SX0 = 1'b1;
    checks++; if (bus.RES_RX1 !== {64'd0, 64'hFFFF_FFFF_FFFF_FFFD}) begin failures++; $display("FAIL ones_res got=%h exp=%h", bus.RES_RX1, {64'd0, 64'hFFFF_FFFF_FFFF_FFFD}); end
    checks++; if ({bus.SELECT_MSB_RX1, bus.SIGNED_RES_RX1} !== 2'b01) begin failures++; $display("FAIL ones_flags got=%b exp=01", {bus.SELECT_MSB_RX1, bus.SIGNED_RES_RX1}); end
    bus.X1X2_POP_SX2 = 1'b1;
    @(posedge clk); #1;
    bus.X1X2_POP_SX2 = 1'b0;
    checks++; if (bus.X1X2_EMPTY_SX1 !== 1'b1) begin failures++; $display("FAIL ones_drained got=%b exp=1", bus.X1X2_EMPTY_SX1); end
  endtask

  // v0 alone carries the value, so each entry's sum is 100+k with carry 0.
  task automatic test_back_to_back();
    bus.X0X1_EMPTY_SX0 = 1'b0;
    drive_x0(64'd100, '0, '0, '0, '0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.X0X1_POP_SX1 !== 1'b1) begin failures++; $display("FAIL bp_push0 got=%b exp=1", bus.X0X1_POP_SX1); end
    @(posedge clk); #1;
    drive_x0(64'd101, '0, '0, '0, '0, 1'b1, 1'b0);
    #1;
    checks++; if (bus.X0X1_POP_SX1 !== 1'b1) begin failures++; $display("FAIL bp_push1 got=%b exp=1", bus.X0X1_POP_SX1); end
    @(posedge clk); #1;
    drive_x0(64'd102, '0, '0, '0, '0, 1'b0, 1'b1);
    #1;
    checks++; if (bus.X0X1_POP_SX1 !== 1'b0) begin failures++; $display("FAIL bp_full_stall got=%b exp=0", bus.X0X1_POP_SX1); end
    checks++; if (bus.RES_RX1 !== {64'd0, 64'd100}) begin failures++; $display("FAIL bp_head0 got=%h exp=%h", bus.RES_RX1, {64'd0, 64'd100}); end
    @(posedge clk); #1;
    bus.X1X2_POP_SX2 = 1'b1;
    #1;
    checks++; if (bus.X0X1_POP_SX1 !== 1'b1) begin failures++; $display("FAIL bp_passthru got=%b exp=1", bus.X0X1_POP_SX1); end
    @(posedge clk); #1;
    bus.X1X2_POP_SX2 = 1'b0;
    drive_x0(64'd103, '0, '0, '0, '0, 1'b1, 1'b1);
    #1;
    checks++; if (bus.X0X1_POP_SX1 !== 1'b0) begin failures++; $display("FAIL bp_still_full got=%b exp=0", bus.X0X1_POP_SX1); end
    checks++; if ({bus.SELECT_MSB_RX1, bus.RES_RX1} !== {1'b1, 64'd0, 64'd101}) begin failures++; $display("FAIL bp_head1 got=%h exp=%h", {bus.SELECT_MSB_RX1, bus.RES_RX1}, {1'b1, 64'd0, 64'd101}); end
    bus.X0X1_EMPTY_SX0 = 1'b1;
    bus.X1X2_POP_SX2   = 1'b1;
    @(posedge clk); #1;
    checks++; if ({bus.SIGNED_RES_RX1, bus.RES_RX1} !== {1'b1, 64'd0, 64'd102}) begin failures++; $display("FAIL bp_head2 got=%h exp=%h", {bus.SIGNED_RES_RX1, bus.RES_RX1}, {1'b1, 64'd0, 64'd102}); end
    @(posedge clk); #1;
    bus.X1X2_POP_SX2 = 1'b0;
    checks++; if (bus.X1X2_EMPTY_SX1 !== 1'b1) begin failures++; $display("FAIL bp_drained got=%b exp=1", bus.X1X2_EMPTY_SX1); end
  endtask

  task automatic test_wrap_stream();
    logic [63:0] sv [10][5];
    logic        sf [10];
    logic        gf [10];
    logic [65:0] q [$];
    logic [65:0] exp_e;
    logic [63:0] tot, got;
    int          idx = 0;
    int          rcv = 0;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 5; j++) sv[k][j] = {$urandom(), $urandom()};
      sf[k] = 1'($urandom_range(0, 1));
      gf[k] = 1'($urandom_range(0, 1));
    end
    for (int cyc = 0; cyc < 200 && rcv < 10; cyc++) begin
      if (idx < 10) begin
        drive_x0(sv[idx][0], sv[idx][1], sv[idx][2], sv[idx][3], sv[idx][4], sf[idx], gf[idx]);
        bus.X0X1_EMPTY_SX0 = 1'b0;
      end else begin
        bus.X0X1_EMPTY_SX0 = 1'b1;
      end
      bus.X1X2_POP_SX2 = bus.X1X2_EMPTY_SX1 ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      if (bus.X0X1_POP_SX1 === 1'b1 && idx < 10) begin
        tot = sv[idx][0] + sv[idx][1] + sv[idx][2] + sv[idx][3] + sv[idx][4];
        q.push_back({sf[idx], gf[idx], tot});
        idx++;
      end
      if (bus.X1X2_POP_SX2) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL stream_spurious got=entry exp=none");
        end else begin
          exp_e = q.pop_front();
          got   = bus.RES_RX1[63:0] + bus.RES_RX1[127:64];
          if ({bus.SELECT_MSB_RX1, bus.SIGNED_RES_RX1, got} !== exp_e) begin
            failures++; $display("FAIL stream_entry%0d got=%h exp=%h", rcv, {bus.SELECT_MSB_RX1, bus.SIGNED_RES_RX1, got}, exp_e);
          end
        end
        rcv++;
      end
      @(posedge clk); #1;
    end
    bus.X1X2_POP_SX2   = 1'b0;
    bus.X0X1_EMPTY_SX0 = 1'b1;
    #1;
    checks++; if (rcv !== 10) begin failures++; $display("FAIL stream_count got=%0d exp=10", rcv); end
    checks++; if (bus.X1X2_EMPTY_SX1 !== 1'b1) begin failures++; $display("FAIL stream_drained got=%b exp=1", bus.X1X2_EMPTY_SX1); end
  endtask

  task automatic test_reset_mid();
    drive_x0(64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 1'b1, 1'b0);
    bus.X0X1_EMPTY_SX0 = 1'b0;
    @(posedge clk); #1;
    drive_x0(ONES, ONES, ONES, 64'd0, 64'd0, 1'b0, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.X1X2_EMPTY_SX1 !== 1'b1) begin failures++; $display("FAIL rmid_empty got=%b exp=1", bus.X1X2_EMPTY_SX1); end
    checks++; if (bus.RES_RX1 !== 128'd0) begin failures++; $display("FAIL rmid_res got=%h exp=0", bus.RES_RX1); end
    checks++; if (bus.X0X1_POP_SX1 !== 1'b1) begin failures++; $display("FAIL rmid_pop got=%b exp=1", bus.X0X1_POP_SX1); end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    bus.X0X1_EMPTY_SX0 = 1'b1;
    checks++; if (bus.RES_RX1 !== {64'd0, 64'hFFFF_FFFF_FFFF_FFFD}) begin failures++; $display("FAIL rmid_first_res got=%h exp=%h", bus.RES_RX1, {64'd0, 64'hFFFF_FFFF_FFFF_FFFD}); end
    checks++; if ({bus.SELECT_MSB_RX1, bus.SIGNED_RES_RX1} !== 2'b01) begin failures++; $display("FAIL rmid_first_flags got=%b exp=01", {bus.SELECT_MSB_RX1, bus.SIGNED_RES_RX1}); end
    bus.X1X2_POP_SX2 = 1'b1;
    @(posedge clk); #1;
    bus.X1X2_POP_SX2 = 1'b0;
    checks++; if (bus.X1X2_EMPTY_SX1 !== 1'b1) begin failures++; $display("FAIL rmid_old_lost got=%b exp=1", bus.X1X2_EMPTY_SX1); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_all_ones();
    test_back_to_back();
    test_wrap_stream();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
